// File: rtl/node_info_engine.sv
// Node-info register block for an EER-RL cluster node: identity, hop count, role,
// TDMA slot, low-energy flag and the initial Q-value from a restoring divider.
module node_info_engine #(
  parameter int               WORD_W  = 16,
  parameter int               FRAC_W  = 14,
  parameter logic [WORD_W-1:0] NODE_ID = 16'h000C,
  parameter bit               HOP_MIN = 1'b1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en_MNI,
  input  logic [2:0]        fPktType,
  input  logic [WORD_W-1:0] e_max,
  input  logic [WORD_W-1:0] e_min,
  input  logic [WORD_W-1:0] energy,
  input  logic [WORD_W-1:0] e_threshold,
  input  logic [WORD_W-1:0] ch_ID,
  input  logic [WORD_W-1:0] hops,
  input  logic [WORD_W-1:0] timeslot,
  output logic [WORD_W-1:0] myNodeID,
  output logic [WORD_W-1:0] hopsFromSink,
  output logic [WORD_W-1:0] myQValue,
  output logic [WORD_W-1:0] myTimeslot,
  output logic              role,
  output logic              low_E,
  output logic              busy,
  output logic              done,
  output logic              drop
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_e;

  localparam logic [2:0]        PT_HB    = 3'b000;
  localparam logic [2:0]        PT_CHE   = 3'b001;
  localparam logic [2:0]        PT_TS    = 3'b011;
  localparam int                CNT_W    = $clog2(FRAC_W + 1);
  localparam logic [WORD_W-1:0] ALL_ONES = '1;
  localparam logic [WORD_W-1:0] ONE_W    = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_W-1:0] Q_ONE    = ONE_W << FRAC_W;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAC_W - 1);

  state_e state_q, state_d;

  logic [2:0]        type_q;
  logic [WORD_W-1:0] emax_q, emin_q, energy_q, thr_q, ch_q, hops_in_q, ts_in_q;
  logic [WORD_W-1:0] den_q, quot_q;
  logic [WORD_W:0]   rem_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [WORD_W-1:0] hops_q, q_val_q, ts_q;
  logic              role_q, low_e_q, busy_q, done_q, drop_q;

  logic [WORD_W-1:0] num_s, den_s, hop_inc_s;
  logic [WORD_W:0]   rem_shift_s, rem_sub_s;
  logic              rem_ge_s, fast_zero_s, fast_s, hop_take_s;

  // Divider step, fast-path detection and saturating hop update
  always_comb begin
    num_s       = energy_q - emin_q;
    den_s       = emax_q - emin_q;
    fast_zero_s = (energy_q <= emin_q) || (den_s == '0);
    fast_s      = fast_zero_s || (energy_q >= emax_q);
    rem_shift_s = rem_q << 1;
    rem_ge_s    = rem_shift_s >= {1'b0, den_q};
    rem_sub_s   = rem_shift_s - {1'b0, den_q};
    hop_inc_s   = (hops_in_q == ALL_ONES) ? ALL_ONES : hops_in_q + ONE_W;
    hop_take_s  = !HOP_MIN || (hop_inc_s < hops_q) || (hops_q == ALL_ONES);
  end

  // State register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en_MNI) state_d = (fPktType == PT_HB) ? S_PREP : S_DONE;
        else        state_d = S_IDLE;
      end
      S_PREP: state_d = fast_s ? S_DONE : S_DIV;
      S_DIV: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   state_d = S_DIV;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture, divider datapath and output registers
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      type_q    <= 3'b000;
      emax_q    <= '0;
      emin_q    <= '0;
      energy_q  <= '0;
      thr_q     <= '0;
      ch_q      <= '0;
      hops_in_q <= '0;
      ts_in_q   <= '0;
      den_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      hops_q    <= ALL_ONES;
      q_val_q   <= '0;
      ts_q      <= '0;
      role_q    <= 1'b0;
      low_e_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= en_MNI && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (en_MNI) begin
            type_q    <= fPktType;
            emax_q    <= e_max;
            emin_q    <= e_min;
            energy_q  <= energy;
            thr_q     <= e_threshold;
            ch_q      <= ch_ID;
            hops_in_q <= hops;
            ts_in_q   <= timeslot;
            busy_q    <= 1'b1;
          end
        end
        S_PREP: begin
          rem_q  <= {1'b0, num_s};
          den_q  <= den_s;
          cnt_q  <= '0;
          // Fast-path result is parked in the quotient so DONE has one source
          quot_q <= (!fast_zero_s && (energy_q >= emax_q)) ? Q_ONE : '0;
        end
        S_DIV: begin
          rem_q  <= rem_ge_s ? rem_sub_s : rem_shift_s;
          quot_q <= {quot_q[WORD_W-2:0], rem_ge_s};
          cnt_q  <= cnt_q + CNT_ONE;
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          case (type_q)
            PT_HB: begin
              q_val_q <= quot_q;
              low_e_q <= energy_q < thr_q;
              role_q  <= 1'b0;
              if (hop_take_s) hops_q <= hop_inc_s;
            end
            PT_CHE: begin
              if (ch_q == NODE_ID) role_q <= 1'b1;
            end
            PT_TS: begin
              if (ch_q == NODE_ID) ts_q <= ts_in_q;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign myNodeID     = NODE_ID;
  assign hopsFromSink = hops_q;
  assign myQValue     = q_val_q;
  assign myTimeslot   = ts_q;
  assign role         = role_q;
  assign low_E        = low_e_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign drop         = drop_q;

endmodule

// File: tb/tb_node_info_engine.sv
// Directed and randomized checks of node_info_engine against a behavioural model.
module tb_node_info_engine;
  localparam int          F   = 14;
  localparam logic [15:0] NID = 16'h000C;

  logic        clk = 1'b0, nrst = 1'b1, en_MNI = 1'b0;
  logic [2:0]  fPktType = 3'b000;
  logic [15:0] e_max = 16'h0, e_min = 16'h0, energy = 16'h0, e_threshold = 16'h0;
  logic [15:0] ch_ID = 16'h0, hops = 16'h0, timeslot = 16'h0;
  logic [15:0] myNodeID, hopsFromSink, myQValue, myTimeslot;
  logic        role, low_E, busy, done, drop;

  int checks = 0, errors = 0, edges = 0;
  logic [15:0] m_hops = 16'hFFFF, m_q = 16'h0, m_ts = 16'h0;
  logic        m_role = 1'b0, m_lowe = 1'b0;
  logic [15:0] r_emax, r_emin, r_en, r_ch, r_hp;
  logic [2:0]  r_type;

  node_info_engine dut (
    .clk(clk), .nrst(nrst), .en_MNI(en_MNI), .fPktType(fPktType),
    .e_max(e_max), .e_min(e_min), .energy(energy), .e_threshold(e_threshold),
    .ch_ID(ch_ID), .hops(hops), .timeslot(timeslot),
    .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .myTimeslot(myTimeslot), .role(role), .low_E(low_E),
    .busy(busy), .done(done), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Q = (energy - e_min) / (e_max - e_min) in 1.FRAC fixed point, truncated, clamped to [0, 1]
  function automatic logic [15:0] ref_q(input logic [15:0] mx, input logic [15:0] mn, input logic [15:0] en);
    logic [15:0] d;
    longint unsigned num;
    d = mx - mn;
    if (en <= mn || d == 16'h0) return 16'h0;
    if (en >= mx) return 16'h4000;
    num = longint'(en - mn);
    return 16'((num * 64'd16384) / longint'(d));
  endfunction

  task automatic start_pkt(input logic [2:0] t, input logic [15:0] mx, input logic [15:0] mn,
                           input logic [15:0] en, input logic [15:0] thr, input logic [15:0] ch,
                           input logic [15:0] hp, input logic [15:0] ts);
    fPktType = t; e_max = mx; e_min = mn; energy = en; e_threshold = thr;
    ch_ID = ch; hops = hp; timeslot = ts;
    en_MNI = 1'b1;
    edges = 0;
    tick();
    en_MNI = 1'b0;
    check("busy_after_capture", busy, 1'b1);
    check("no_drop_on_accept", drop, 1'b0);
    check("done_low_after_capture", done, 1'b0);
  endtask

  task automatic finish_pkt(input int lat);
    while (!done && edges < 60) tick();
    check("latency", edges, lat);
    check("done_pulse", done, 1'b1);
    check("busy_clear", busy, 1'b0);
    check("hopsFromSink", hopsFromSink, m_hops);
    check("myQValue", myQValue, m_q);
    check("myTimeslot", myTimeslot, m_ts);
    check("role", role, m_role);
    check("low_E", low_E, m_lowe);
    check("myNodeID", myNodeID, NID);
  endtask

  task automatic send(input logic [2:0] t, input logic [15:0] mx, input logic [15:0] mn,
                      input logic [15:0] en, input logic [15:0] thr, input logic [15:0] ch,
                      input logic [15:0] hp, input logic [15:0] ts);
    int lat;
    logic [15:0] inc;
    start_pkt(t, mx, mn, en, thr, ch, hp, ts);
    lat = 2;
    if (t == 3'd0) begin
      lat = (en <= mn || mx == mn || en >= mx) ? 3 : F + 3;
      m_q = ref_q(mx, mn, en);
      m_lowe = en < thr;
      m_role = 1'b0;
      inc = (hp == 16'hFFFF) ? 16'hFFFF : hp + 16'd1;
      if (inc < m_hops || m_hops == 16'hFFFF) m_hops = inc;
    end else if (t == 3'd1) begin
      if (ch == NID) m_role = 1'b1;
    end else if (t == 3'd3) begin
      if (ch == NID) m_ts = ts;
    end
    finish_pkt(lat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    tick();
    check("rst_hops", hopsFromSink, 16'hFFFF);
    check("rst_q", myQValue, 16'h0);
    check("rst_role", role, 1'b0);
    check("rst_lowe", low_E, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    send(3'd0, 16'h8000, 16'h4000, 16'h6000, 16'h3333, 16'h0, 16'd1, 16'h0);
    check("t2_q_const", myQValue, 16'h2000);
    check("t2_hops_const", hopsFromSink, 16'd2);
    send(3'd0, 16'h8000, 16'h4000, 16'h8000, 16'h3333, 16'h0, 16'd1, 16'h0);
    check("t3_q_const", myQValue, 16'h4000);
    send(3'd0, 16'h8000, 16'h4000, 16'h6000, 16'h3333, 16'h0, 16'd3, 16'h0);
    check("t3_hops_kept", hopsFromSink, 16'd2);
    send(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0020, 16'h0, 16'h0);
    send(3'd2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0020, 16'h0, 16'h0);
    send(3'd1, 16'h0, 16'h0, 16'h0, 16'h0, NID, 16'h0, 16'h0);
    check("t4_role_const", role, 1'b1);
    send(3'd0, 16'h8000, 16'h4000, 16'h5000, 16'h3333, 16'h0, 16'd5, 16'h0);
    check("t4_role_cleared", role, 1'b0);
    send(3'd0, 16'h8000, 16'h4000, 16'h3000, 16'h3333, 16'h0, 16'd5, 16'h0);
    check("t5_lowe_const", low_E, 1'b1);
    check("t5_q_const", myQValue, 16'h0);
    send(3'd3, 16'h0, 16'h0, 16'h0, 16'h0, NID, 16'h0, 16'd5);
    check("t5_ts_const", myTimeslot, 16'd5);
    send(3'd5, 16'h0, 16'h0, 16'h0, 16'h0, NID, 16'h0, 16'd9);

    // Request during a divide is dropped and must not disturb the result
    start_pkt(3'd0, 16'hF000, 16'h1000, 16'h7777, 16'h0100, 16'h0, 16'd9, 16'h0);
    m_q = ref_q(16'hF000, 16'h1000, 16'h7777);
    m_lowe = 1'b0;
    m_role = 1'b0;
    repeat (3) tick();
    fPktType = 3'd1; ch_ID = NID; en_MNI = 1'b1;
    tick();
    en_MNI = 1'b0;
    check("drop_pulse", drop, 1'b1);
    tick();
    check("drop_one_cycle", drop, 1'b0);
    finish_pkt(F + 3);

    // Reset in the middle of a divide
    start_pkt(3'd0, 16'hF000, 16'h1000, 16'h9000, 16'h0100, 16'h0, 16'd0, 16'h0);
    repeat (5) tick();
    nrst = 1'b1;
    #1;
    check("midrst_q", myQValue, 16'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_hops", hopsFromSink, 16'hFFFF);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    m_hops = 16'hFFFF; m_q = 16'h0; m_ts = 16'h0; m_role = 1'b0; m_lowe = 1'b0;
    send(3'd2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    for (int i = 0; i < 60; i++) begin
      r_type = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) r_type = 3'd0;
      r_emin = 16'($urandom);
      r_emax = 16'($urandom);
      if ($urandom_range(0, 9) < 8 && r_emax < r_emin) begin
        r_hp = r_emax; r_emax = r_emin; r_emin = r_hp;
      end
      if ($urandom_range(0, 9) == 0) r_emax = r_emin;
      case ($urandom_range(0, 4))
        0:       r_en = r_emin;
        1:       r_en = r_emax;
        2:       r_en = 16'($urandom);
        default: r_en = (r_emax > r_emin) ? r_emin + 16'($urandom % (r_emax - r_emin)) : r_emin;
      endcase
      r_ch = ($urandom_range(0, 1) == 1) ? NID : 16'($urandom);
      r_hp = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
      send(r_type, r_emax, r_emin, r_en, 16'($urandom), r_ch, r_hp, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
